red_pitaya_acq_double_buf: RTL and testbench

Double-buffered (ping-pong) ADC acquisition block: captures a triggered, optionally decimated burst of ADC samples into one of two RAM banks while the CPU reads the other bank over the system bus. It is the capture-side counterpart of the double-buffered signal generator, sits in the ADC clock domain next to the ASG, and shares its trigger lines and sys_bus register/table conventions.

---
 rtl/red_pitaya_acq_pkg.sv | 28 ++
 rtl/red_pitaya_acq_bank.sv | 27 ++
 rtl/red_pitaya_acq_double_buf.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_red_pitaya_acq_double_buf.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_acq_pkg.sv
// Shared types and constants for the double-buffered ADC acquisition block.
package red_pitaya_acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } acq_state_t;

    // Register offsets within the block's 20-bit address window
    localparam logic [19:0] ADDR_CTRL = 20'h0_0000;
    localparam logic [19:0] ADDR_STAT = 20'h0_0004;
    localparam logic [19:0] ADDR_LEN  = 20'h0_0008;
    localparam logic [19:0] ADDR_DEC  = 20'h0_000C;
    localparam logic [19:0] ADDR_WPTR = 20'h0_0010;
    localparam logic [19:0] ADDR_TS0  = 20'h0_0018;
    localparam logic [19:0] ADDR_TS1  = 20'h0_001C;

    // Sample tables live in 64 KiB pages selected by address bits [19:16]
    localparam logic [3:0] RAM_PAGE0 = 4'h1;
    localparam logic [3:0] RAM_PAGE1 = 4'h2;

    localparam logic [2:0] TRIG_OFF  = 3'd0;
    localparam logic [2:0] TRIG_NOW  = 3'd1;
    localparam logic [2:0] TRIG_RISE = 3'd2;
    localparam logic [2:0] TRIG_FALL = 3'd3;

endpackage

// File: rtl/red_pitaya_acq_bank.sv
// One sample bank: simple dual-port RAM, single write port, registered read port.
module red_pitaya_acq_bank #(
    parameter int ADC_DW = 14,
    parameter int RSZ    = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RSZ-1:0]    waddr,
    input  logic [ADC_DW-1:0] wdata,
    input  logic [RSZ-1:0]    raddr,
    output logic [ADC_DW-1:0] rdata
);

    logic [ADC_DW-1:0] mem_q [2**RSZ];
    logic [ADC_DW-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/red_pitaya_acq_double_buf.sv
// Ping-pong ADC capture into two RAM banks with sys_bus register/table access.
// Optional trigger timestamps per bank when ACQ_TRIG_TS_EN is defined.
//   state   | meaning
//   IDLE    | waiting for ARM
//   ARMED   | waiting for a trigger event on a free write bank
//   CAPTURE | writing LEN+1 samples, one per decimation period
module red_pitaya_acq_double_buf
    import red_pitaya_acq_pkg::*;
#(
    parameter int ADC_DW = 14,
    parameter int RSZ    = 14
) (
    input  logic              adc_clk_i,
    input  logic              adc_rstn_i,
    input  logic [ADC_DW-1:0] adc_i,
    input  logic              trig_i,
    output logic              trig_out_o,
    output logic              irq_o,
    input  logic [31:0]       sys_addr,
    input  logic [31:0]       sys_wdata,
    input  logic [3:0]        sys_sel,
    input  logic              sys_wen,
    input  logic              sys_ren,
    output logic [31:0]       sys_rdata,
    output logic              sys_err,
    output logic              sys_ack
);

    acq_state_t        state_q, state_d;
    logic [2:0]        trig_src_q, trig_src_d;
    logic              cont_q, cont_d;
    logic [RSZ-1:0]    len_q, len_d, len_sh_q, len_sh_d;
    logic [16:0]       dec_q, dec_d, dec_sh_q, dec_sh_d;
    logic [16:0]       dec_cnt_q, dec_cnt_d, dec_reload;
    logic [RSZ-1:0]    wptr_q, wptr_d;
    logic              bank_q, bank_d;
    logic [1:0]        rdy_q, rdy_d;
    logic              ovr_q, ovr_d;
    logic              trig_d1_q;
    logic              trig_out_q, trig_out_d;
    logic              ack_q, ack_d;
    logic              ram_pend_q, ram_pend_d;
    logic              ram_bank_q, ram_bank_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       reg_rdata, ts0_rd, ts1_rd;
    logic [ADC_DW-1:0] rd0, rd1, rd_sel;

    logic [19:0] addr_lo;
    logic        is_ram0, is_ram1, is_ram;
    logic        wr_ctrl, wr_stat, wr_len, wr_dec;
    logic        arm_req, rst_req;
    logic        trig_evt, rdy_cur;
    logic        cap_start, ovr_hit, cap_we, cap_done;

    assign addr_lo = sys_addr[19:0];
    assign is_ram0 = (addr_lo[19:16] == RAM_PAGE0);
    assign is_ram1 = (addr_lo[19:16] == RAM_PAGE1);
    assign is_ram  = is_ram0 | is_ram1;

    assign wr_ctrl = sys_wen && (addr_lo == ADDR_CTRL);
    assign wr_stat = sys_wen && (addr_lo == ADDR_STAT);
    assign wr_len  = sys_wen && (addr_lo == ADDR_LEN);
    assign wr_dec  = sys_wen && (addr_lo == ADDR_DEC);
    assign arm_req = wr_ctrl && sys_wdata[0];
    assign rst_req = wr_ctrl && sys_wdata[1];

    always_comb begin
        trig_evt = 1'b0;
        case (trig_src_q)
            TRIG_OFF:  trig_evt = 1'b0;
            TRIG_NOW:  trig_evt = 1'b1;
            TRIG_RISE: trig_evt = trig_i && !trig_d1_q;
            TRIG_FALL: trig_evt = !trig_i && trig_d1_q;
            default:   trig_evt = 1'b0;
        endcase
    end

    assign rdy_cur    = rdy_q[bank_q];
    assign cap_start  = (state_q == ST_ARMED) && trig_evt && !rdy_cur && !rst_req;
    assign ovr_hit    = (state_q == ST_ARMED) && trig_evt && rdy_cur && !rst_req;
    assign cap_we     = (state_q == ST_CAPTURE) && (dec_cnt_q == '0) && !rst_req;
    assign cap_done   = cap_we && (wptr_q == len_sh_q);
    assign dec_reload = (dec_sh_q > 17'd1) ? dec_sh_q - 17'd1 : '0;

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rst_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (arm_req) state_d = ST_ARMED;
                ST_ARMED:   if (cap_start) state_d = ST_CAPTURE;
                ST_CAPTURE: if (cap_done) state_d = cont_q ? ST_ARMED : ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        trig_src_d = trig_src_q;
        cont_d     = cont_q;
        len_d      = len_q;
        dec_d      = dec_q;
        len_sh_d   = len_sh_q;
        dec_sh_d   = dec_sh_q;
        dec_cnt_d  = dec_cnt_q;
        wptr_d     = wptr_q;
        bank_d     = bank_q;
        trig_out_d = 1'b0;

        if (wr_ctrl) begin
            trig_src_d = sys_wdata[4:2];
            cont_d     = sys_wdata[8];
        end
        if (wr_len) len_d = sys_wdata[RSZ-1:0];
        if (wr_dec) dec_d = sys_wdata[16:0];

        // Shadows isolate the running capture from mid-capture config writes
        if (cap_start) begin
            len_sh_d   = len_q;
            dec_sh_d   = dec_q;
            dec_cnt_d  = '0;
            wptr_d     = '0;
            trig_out_d = 1'b1;
        end

        if (cap_we) begin
            wptr_d    = wptr_q + RSZ'(1);
            dec_cnt_d = dec_reload;
        end else if ((state_q == ST_CAPTURE) && (dec_cnt_q != '0)) begin
            dec_cnt_d = dec_cnt_q - 17'd1;
        end

        // W1C applied first so a same-cycle completion keeps its RDY bit
        rdy_d = rdy_q & ~({2{wr_stat}} & sys_wdata[5:4]);
        ovr_d = (ovr_q && !(wr_stat && sys_wdata[8])) || ovr_hit;
        if (cap_done) begin
            rdy_d[bank_q] = 1'b1;
            bank_d        = !bank_q;
        end

        if (rst_req) begin
            rdy_d  = '0;
            ovr_d  = 1'b0;
            bank_d = 1'b0;
            wptr_d = '0;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (addr_lo)
            ADDR_CTRL: reg_rdata = {23'd0, cont_q, 3'd0, trig_src_q, 2'd0};
            ADDR_STAT: reg_rdata = {23'd0, ovr_q, 1'b0, bank_q, rdy_q, 2'd0, state_q};
            ADDR_LEN:  reg_rdata = {{(32-RSZ){1'b0}}, len_q};
            ADDR_DEC:  reg_rdata = {15'd0, dec_q};
            ADDR_WPTR: reg_rdata = {{(32-RSZ){1'b0}}, wptr_q};
            ADDR_TS0:  reg_rdata = ts0_rd;
            ADDR_TS1:  reg_rdata = ts1_rd;
            default:   reg_rdata = '0;
        endcase
    end

    // Register reads answer in one cycle; table reads wait one more for the RAM register
    assign rd_sel = ram_bank_q ? rd1 : rd0;
    always_comb begin
        ack_d      = sys_wen || (sys_ren && !is_ram) || ram_pend_q;
        ram_pend_d = sys_ren && is_ram;
        ram_bank_d = is_ram1;
        rdata_d    = '0;
        if (ram_pend_q) begin
            rdata_d = {{(32-ADC_DW){rd_sel[ADC_DW-1]}}, rd_sel};
        end else if (sys_ren && !is_ram) begin
            rdata_d = reg_rdata;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            trig_src_q <= TRIG_OFF;
            cont_q     <= 1'b0;
            len_q      <= '1;
            dec_q      <= '0;
            len_sh_q   <= '1;
            dec_sh_q   <= '0;
            dec_cnt_q  <= '0;
            wptr_q     <= '0;
            bank_q     <= 1'b0;
            rdy_q      <= '0;
            ovr_q      <= 1'b0;
            trig_d1_q  <= 1'b0;
            trig_out_q <= 1'b0;
            ack_q      <= 1'b0;
            ram_pend_q <= 1'b0;
            ram_bank_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            trig_src_q <= trig_src_d;
            cont_q     <= cont_d;
            len_q      <= len_d;
            dec_q      <= dec_d;
            len_sh_q   <= len_sh_d;
            dec_sh_q   <= dec_sh_d;
            dec_cnt_q  <= dec_cnt_d;
            wptr_q     <= wptr_d;
            bank_q     <= bank_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            trig_d1_q  <= trig_i;
            trig_out_q <= trig_out_d;
            ack_q      <= ack_d;
            ram_pend_q <= ram_pend_d;
            ram_bank_q <= ram_bank_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef ACQ_TRIG_TS_EN
    logic [31:0] cyc_q, cyc_d, ts0_q, ts0_d, ts1_q, ts1_d;

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        ts0_d = ts0_q;
        ts1_d = ts1_q;
        if (cap_start) begin
            if (bank_q) ts1_d = cyc_q;
            else        ts0_d = cyc_q;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            cyc_q <= '0;
            ts0_q <= '0;
            ts1_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ts0_q <= ts0_d;
            ts1_q <= ts1_d;
        end
    end

    assign ts0_rd = ts0_q;
    assign ts1_rd = ts1_q;
`else
    assign ts0_rd = '0;
    assign ts1_rd = '0;
`endif

    red_pitaya_acq_bank #(.ADC_DW(ADC_DW), .RSZ(RSZ)) u_bank0 (
        .clk   (adc_clk_i),
        .we    (cap_we && !bank_q),
        .waddr (wptr_q),
        .wdata (adc_i),
        .raddr (sys_addr[RSZ+1:2]),
        .rdata (rd0)
    );

    red_pitaya_acq_bank #(.ADC_DW(ADC_DW), .RSZ(RSZ)) u_bank1 (
        .clk   (adc_clk_i),
        .we    (cap_we && bank_q),
        .waddr (wptr_q),
        .wdata (adc_i),
        .raddr (sys_addr[RSZ+1:2]),
        .rdata (rd1)
    );

    logic unused_bits;
    assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata[31:17]};

    assign trig_out_o = trig_out_q;
    assign irq_o      = |rdy_q;
    assign sys_rdata  = rdata_q;
    assign sys_ack    = ack_q;
    assign sys_err    = 1'b0;

endmodule

// File: tb/tb_red_pitaya_acq_double_buf.sv
// Directed bench for red_pitaya_acq_double_buf; also covers ACQ_TRIG_TS_EN when defined.
module tb_red_pitaya_acq_double_buf;

    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] adc_i;
    logic        trig_i;
    logic        trig_out;
    logic        irq;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic [3:0]  sys_sel;
    logic        sys_wen, sys_ren, sys_err, sys_ack;

    int   tb_cyc;
    int   adc_off;
    bit   adc_ramp;
    logic [13:0] adc_const;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   c0, c1, c2, c3, c4;
`ifdef ACQ_TRIG_TS_EN
    int   exp_ts0;
`endif

    always #4 clk = ~clk;

    // Cycle index, changes right after each rising edge like a register output
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    assign adc_i = adc_ramp ? 14'(tb_cyc + adc_off) : adc_const;

    red_pitaya_acq_double_buf #(.ADC_DW(14), .RSZ(14)) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rstn),
        .adc_i      (adc_i),
        .trig_i     (trig_i),
        .trig_out_o (trig_out),
        .irq_o      (irq),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_sel    (sys_sel),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        @(negedge clk);
        sys_wen   = 1'b0;
        chk("wr_ack", {31'd0, sys_ack}, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input int exp_lat);
        logic [31:0] d;
        int          lat;
        sys_addr = a;
        sys_ren  = 1'b1;
        d        = 'x;
        lat      = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            sys_ren = 1'b0;
            if (sys_ack) begin
                lat = i;
                d   = sys_rdata;
                break;
            end
        end
        chk(tag, d, exp);
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        trig_i    = 1'b0;
        sys_addr  = '0;
        sys_wdata = '0;
        sys_sel   = 4'hF;
        sys_wen   = 1'b0;
        sys_ren   = 1'b0;
        adc_ramp  = 1'b0;
        adc_const = '0;
        adc_off   = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {28'd0, trig_out, irq, sys_ack, sys_err}, 32'd0);
        chk("rst_rdata", sys_rdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        rd_chk("rst_ctrl", 32'h00, 32'h0, 1);
        rd_chk("rst_stat", 32'h04, 32'h0, 1);
        rd_chk("rst_len",  32'h08, 32'h3FFF, 1);
        rd_chk("rst_dec",  32'h0C, 32'h0, 1);
        rd_chk("rst_wptr", 32'h10, 32'h0, 1);

        // Single immediate capture of a ramp into bank0
        wr(32'h08, 32'd7);
        wr(32'h0C, 32'd0);
        adc_ramp = 1'b1;
        adc_off  = 100 - (tb_cyc + 2);
`ifdef ACQ_TRIG_TS_EN
        exp_ts0 = tb_cyc + 1;
`endif
        wr(32'h00, 32'h5);
        chk("t1_trig_out_armed", {31'd0, trig_out}, 32'd0);
        @(negedge clk);
        chk("t1_trig_out_cap", {31'd0, trig_out}, 32'd1);
        repeat (7) @(negedge clk);
        chk("t1_irq_last_write", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("t1_irq_rdy", {31'd0, irq}, 32'd1);
        adc_ramp = 1'b0;
        rd_chk("t1_stat", 32'h04, 32'h50, 1);
        rd_chk("t1_wptr", 32'h10, 32'd8, 1);
        for (int k = 0; k < 8; k++)
            rd_chk("t1_bank0", 32'h10000 + 32'(4 * k), 32'(100 + k), 2);
`ifdef ACQ_TRIG_TS_EN
        rd_chk("t1_ts0", 32'h18, 32'(exp_ts0), 1);
`else
        rd_chk("ts0_off", 32'h18, 32'h0, 1);
        rd_chk("ts1_off", 32'h1C, 32'h0, 1);
`endif

        // Decimation by 5 into bank1; W1C of RDY1 lands on the set cycle
        wr(32'h04, 32'h10);
        chk("dec_irq_clr", {31'd0, irq}, 32'd0);
        wr(32'h0C, 32'd5);
        wr(32'h08, 32'd3);
        adc_ramp = 1'b1;
        adc_off  = 0;
        c0 = tb_cyc + 2;
        wr(32'h00, 32'h5);
        @(negedge clk);
        chk("dec_trig_out", {31'd0, trig_out}, 32'd1);
        repeat (15) @(negedge clk);
        chk("dec_irq_pre", {31'd0, irq}, 32'd0);
        wr(32'h04, 32'h20);
        chk("dec_irq_set_wins", {31'd0, irq}, 32'd1);
        adc_ramp = 1'b0;
        rd_chk("dec_stat", 32'h04, 32'h20, 1);
        for (int k = 0; k < 4; k++)
            rd_chk("dec_bank1", 32'h20000 + 32'(4 * k), 32'((c0 + 5 * k) & 32'h3FFF), 2);
        wr(32'h04, 32'h20);

        // Continuous mode, rising-edge trigger, RDY0 cleared between edges
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'h109);
        rd_chk("c_ctrl", 32'h00, 32'h108, 1);
        adc_ramp = 1'b1;
        adc_off  = 0;
        trig_i = 1'b1; c1 = tb_cyc + 1;
        repeat (2) @(negedge clk);
        trig_i = 1'b0;
        repeat (8) @(negedge clk);
        rd_chk("c_stat1", 32'h04, 32'h51, 1);
        wr(32'h04, 32'h10);
        trig_i = 1'b1; c2 = tb_cyc + 1;
        repeat (2) @(negedge clk);
        trig_i = 1'b0;
        repeat (8) @(negedge clk);
        rd_chk("c_stat2", 32'h04, 32'h21, 1);
        rd_chk("c_b0_0", 32'h10000, 32'(c1), 2);
        rd_chk("c_b0_3", 32'h1000C, 32'(c1 + 3), 2);
        rd_chk("c_b1_0", 32'h20000, 32'(c2), 2);
        rd_chk("c_b1_3", 32'h2000C, 32'(c2 + 3), 2);

        // Three edges with no clearing: third finds bank0 still ready
        wr(32'h00, 32'h2);
        rd_chk("o_stat_rst", 32'h04, 32'h0, 1);
        wr(32'h00, 32'h109);
        trig_i = 1'b1; c3 = tb_cyc + 1;
        repeat (2) @(negedge clk);
        trig_i = 1'b0;
        repeat (8) @(negedge clk);
        trig_i = 1'b1; c4 = tb_cyc + 1;
        repeat (2) @(negedge clk);
        trig_i = 1'b0;
        repeat (8) @(negedge clk);
        trig_i = 1'b1;
        repeat (2) @(negedge clk);
        trig_i = 1'b0;
        repeat (8) @(negedge clk);
        rd_chk("o_stat", 32'h04, 32'h131, 1);
        rd_chk("o_b0_0", 32'h10000, 32'(c3), 2);
        rd_chk("o_b0_3", 32'h1000C, 32'(c3 + 3), 2);
        chk("o_irq", {31'd0, irq}, 32'd1);

        // Soft reset in the middle of a long capture
        wr(32'h04, 32'h10);
        wr(32'h08, 32'd100);
        wr(32'h00, 32'h104);
        repeat (4) @(negedge clk);
        rd_chk("r_stat_cap", 32'h04, 32'h122, 1);
        wr(32'h00, 32'h2);
        chk("r_irq", {31'd0, irq}, 32'd0);
        rd_chk("r_stat", 32'h04, 32'h0, 1);
        rd_chk("r_wptr", 32'h10, 32'h0, 1);
        rd_chk("r_ctrl", 32'h00, 32'h0, 1);
        rd_chk("r_b1_kept", 32'h20000, 32'(c4), 2);
        wr(32'h10, 32'h55);
        rd_chk("ro_wptr", 32'h10, 32'h0, 1);
        rd_chk("unmapped", 32'h40, 32'h0, 1);

        // TRIG_SRC=0 never fires; then falling edge captures one negative sample
        adc_ramp  = 1'b0;
        adc_const = 14'h3FFC;
        wr(32'h00, 32'h1);
        repeat (3) @(negedge clk);
        rd_chk("s0_stat", 32'h04, 32'h1, 1);
        wr(32'h08, 32'd0);
        wr(32'h00, 32'h0C);
        trig_i = 1'b1;
        repeat (2) @(negedge clk);
        rd_chk("f_stat_rise", 32'h04, 32'h1, 1);
        trig_i = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("f_stat", 32'h04, 32'h50, 1);
        rd_chk("f_wptr", 32'h10, 32'd1, 1);
        rd_chk("neg_sample", 32'h10000, 32'hFFFF_FFFC, 2);

        // Asynchronous reset during a capture into bank1
        wr(32'h08, 32'd100);
        wr(32'h00, 32'h5);
        repeat (3) @(negedge clk);
        rd_chk("a_stat", 32'h04, 32'h52, 1);
        chk("a_irq_pre", {31'd0, irq}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("a_outs", {28'd0, trig_out, irq, sys_ack, sys_err}, 32'd0);
        chk("a_rdata", sys_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd_chk("a_stat_post", 32'h04, 32'h0, 1);
        rd_chk("a_len_post", 32'h08, 32'h3FFF, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
